// File: rtl/reg_pipe_pkg.sv
// Shared defaults and the occupancy-width helper for the reg_pipe register pipeline.
package reg_pipe_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 2;

   // Bits needed to count 0..depth valid stages (never narrower than 1 bit).
   function automatic int occ_width(input int depth);
      if (depth + 1 <= 2) begin
         return 1;
      end
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline slot: data/valid (and parity when REG_PIPE_PARITY_EN is defined) with ready chaining.
module reg_pipe_stage
   import reg_pipe_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic [WIDTH-1:0] prev_data,
   input  logic             prev_valid,
`ifdef REG_PIPE_PARITY_EN
   input  logic             prev_parity,
   output logic             parity,
`endif
   input  logic             next_ready,
   output logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   // A slot can take new content when it is empty or its content moves on this edge.
   assign ready = !valid || next_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (ready) begin
         valid <= prev_valid;
         // Bubbles leave the data register untouched.
         if (prev_valid) begin
            data <= prev_data;
         end
      end
   end

`ifdef REG_PIPE_PARITY_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         parity <= 1'b0;
      end else if (!flush && ready && prev_valid) begin
         parity <= prev_parity;
      end
   end
`endif

endmodule

// File: rtl/reg_pipe.sv
// Valid/ready register pipeline of DEPTH stages with flush and occupancy count.
// Optional parity tracking is enabled by defining REG_PIPE_PARITY_EN.
module reg_pipe
   import reg_pipe_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          flush,
   input  logic [WIDTH-1:0]              in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
`ifdef REG_PIPE_PARITY_EN
   input  logic                          in_parity,
   output logic                          out_parity_err,
`endif
   output logic [occ_width(DEPTH)-1:0]   occupancy
);

   localparam int OCC_W = occ_width(DEPTH);

   logic [WIDTH-1:0] stage_data [DEPTH];
   logic [DEPTH-1:0] stage_valid;
   logic [DEPTH:0]   stage_ready;
   logic [DEPTH-1:0] valid_next;
   logic [OCC_W-1:0] occupancy_reg;
   logic [OCC_W-1:0] occupancy_next;
`ifdef REG_PIPE_PARITY_EN
   logic [DEPTH-1:0] stage_parity;
`endif

   assign stage_ready[DEPTH] = out_ready;
   assign in_ready           = stage_ready[0] && !flush;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [WIDTH-1:0] prev_data;
         logic             prev_valid;
`ifdef REG_PIPE_PARITY_EN
         logic             prev_parity;
`endif
         if (gi == 0) begin : g_head
            assign prev_data  = in_data;
            assign prev_valid = in_valid && in_ready;
`ifdef REG_PIPE_PARITY_EN
            assign prev_parity = in_parity;
`endif
         end else begin : g_body
            assign prev_data  = stage_data[gi-1];
            assign prev_valid = stage_valid[gi-1];
`ifdef REG_PIPE_PARITY_EN
            assign prev_parity = stage_parity[gi-1];
`endif
         end

         reg_pipe_stage #(
            .WIDTH (WIDTH)
         ) u_stage (
            .clock       (clock),
            .reset       (reset),
            .flush       (flush),
            .prev_data   (prev_data),
            .prev_valid  (prev_valid),
`ifdef REG_PIPE_PARITY_EN
            .prev_parity (prev_parity),
            .parity      (stage_parity[gi]),
`endif
            .next_ready  (stage_ready[gi+1]),
            .ready       (stage_ready[gi]),
            .data        (stage_data[gi]),
            .valid       (stage_valid[gi])
         );

         // Mirror of the stage's valid update, used to keep the count in step with the valids.
         assign valid_next[gi] = flush ? 1'b0
                               : (stage_ready[gi] ? prev_valid : stage_valid[gi]);
      end
   endgenerate

   always_comb begin
      occupancy_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_next[i]) begin
            occupancy_next = occupancy_next + OCC_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         occupancy_reg <= '0;
      end else begin
         occupancy_reg <= occupancy_next;
      end
   end

   assign occupancy = occupancy_reg;
   assign out_data  = stage_data[DEPTH-1];
   assign out_valid = stage_valid[DEPTH-1];

`ifdef REG_PIPE_PARITY_EN
   assign out_parity_err = out_valid && ((^out_data) != stage_parity[DEPTH-1]);
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe: queue-based timing model plus directed literal checks.
// Parity checks are compiled in when REG_PIPE_PARITY_EN is defined.
module tb_reg_pipe;

   localparam int W  = 8;
   localparam int D  = 2;
   localparam int OW = reg_pipe_pkg::occ_width(D);

   logic          clock;
   logic          reset;
   logic          flush;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] occupancy;
   logic          in_parity;
`ifdef REG_PIPE_PARITY_EN
   logic          out_parity_err;
`endif

   reg_pipe #(
      .WIDTH (W),
      .DEPTH (D)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .flush          (flush),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
`ifdef REG_PIPE_PARITY_EN
      .in_parity      (in_parity),
      .out_parity_err (out_parity_err),
`endif
      .occupancy      (occupancy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Model: words in flight in order; arr = first edge index after which the word may sit at the output.
   typedef struct {
      logic [W-1:0] data;
      logic         par;
      int           arr;
   } ent_t;

   ent_t         mq[$];
   logic [W-1:0] got[$];
   int           got_t[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   int           edge_n = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   function automatic bit exp_ov();
      return (mq.size() > 0) && (mq[0].arr <= edge_n);
   endfunction

   function automatic bit exp_ir();
      return !flush && !((mq.size() == D) && !out_ready);
   endfunction

   // Called at a falling edge with inputs already driven; compares, then advances one clock.
   task automatic step();
      bit   ov;
      bit   ir;
      ent_t e;
      #1;
      ov = exp_ov();
      ir = exp_ir();
      chk("out_valid", out_valid, ov);
      chk("in_ready", in_ready, ir);
      chk("occupancy", occupancy, mq.size());
      if (ov) chk("out_data", out_data, mq[0].data);
      if (reset) chk("reset_data", out_data, 0);
`ifdef REG_PIPE_PARITY_EN
      if (ov) chk("parity_err", out_parity_err, ((^mq[0].data) != mq[0].par));
      else    chk("parity_err_idle", out_parity_err, 0);
`endif
      if (ov && out_ready) begin
         got.push_back(out_data);
         got_t.push_back(edge_n);
      end
      @(posedge clock);
      if (!reset) begin
         if (flush) begin
            mq.delete();
         end else begin
            if (ov && out_ready) begin
               void'(mq.pop_front());
               if (mq.size() > 0) begin
                  e = mq.pop_front();
                  if (e.arr < edge_n + 1) e.arr = edge_n + 1;
                  mq.push_front(e);
               end
            end
            if (in_valid && ir) begin
               e.data = in_data;
               e.par  = in_parity;
               e.arr  = edge_n + D;
               mq.push_back(e);
            end
         end
      end
      edge_n++;
      @(negedge clock);
   endtask

   task automatic chk_run(input string name, input int n, input int first);
      chk({name, "_count"}, got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++) begin
         chk({name, "_data"}, got[i], W'(first + i));
         if (i > 0) chk({name, "_gap"}, got_t[i] - got_t[i-1], 1);
      end
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h98;
      in_parity = 1'b0;
      out_ready = 1'b0;

      // Reset applied before any clock edge, with a word offered at the input.
      #1;
      chk("rst_ov", out_valid, 0);
      chk("rst_od", out_data, 8'h00);
      chk("rst_occ", occupancy, 0);
      @(negedge clock);
      step();
      chk("rst_edge_ov", out_valid, 0);
      chk("rst_edge_od", out_data, 8'h00);
      chk("rst_edge_occ", occupancy, 0);
      in_valid = 1'b0;
      reset    = 1'b0;
      step();

      // Latency into an empty pipe.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hE7;
      step();
      in_valid = 1'b0;
      chk("lat_edge1_ov", out_valid, 0);
      step();
      chk("lat_edge2_ov", out_valid, 1);
      chk("lat_edge2_od", out_data, 8'hE7);
      repeat (2) step();

      // Backpressure: only two words fit, then release.
      got.delete(); got_t.delete();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h01; step();
      in_data   = 8'h02; step();
      in_data   = 8'h03; step();
      chk("bp_occ", occupancy, 2);
      chk("bp_in_ready", in_ready, 0);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      chk_run("bp", 3, 1);

      // Sustained throughput.
      got.delete(); got_t.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = W'(i);
         step();
      end
      in_valid = 1'b0;
      repeat (4) step();
      chk_run("tput", 16, 0);

      // Flush of a full pipe with a concurrent input.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hAA; step();
      in_data   = 8'hBB; step();
      chk("fl_full_occ", occupancy, 2);
      flush   = 1'b1;
      in_data = 8'hCC;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_occ", occupancy, 0);
      chk("fl_ov", out_valid, 0);
      got.delete(); got_t.delete();
      out_ready = 1'b1;
      repeat (4) step();
      chk("fl_nothing_out", got.size(), 0);

      // Reset asserted between edges while words are in flight.
      in_valid = 1'b1;
      in_data  = 8'h11; step();
      in_data  = 8'h22; step();
      #3;
      reset = 1'b1;
      mq.delete();
      #1;
      chk("mid_rst_ov", out_valid, 0);
      chk("mid_rst_occ", occupancy, 0);
      chk("mid_rst_od", out_data, 8'h00);
      in_data = 8'h33;
      @(negedge clock);
      edge_n++;
      reset   = 1'b0;
      in_data = 8'h5A;
      step();
      in_valid = 1'b0;
      chk("post_rst_occ", occupancy, 1);
      step();
      chk("post_rst_ov", out_valid, 1);
      chk("post_rst_od", out_data, 8'h5A);
      step();

`ifdef REG_PIPE_PARITY_EN
      // Wrong parity flagged only while that word is at the output.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hFC;
      in_parity = 1'b1;
      step();
      in_valid = 1'b0;
      chk("par_early", out_parity_err, 0);
      step();
      chk("par_bad", out_parity_err, 1);
      step();
      chk("par_gone", out_parity_err, 0);
      in_valid  = 1'b1;
      in_parity = 1'b0;
      step();
      in_valid = 1'b0;
      step();
      chk("par_good_ov", out_valid, 1);
      chk("par_good", out_parity_err, 0);
      step();
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom % 3) != 0;
         in_data   = W'($urandom);
         in_parity = 1'($urandom);
         out_ready = ($urandom % 4) != 0;
         flush     = ($urandom % 40) == 0;
         step();
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
